// File: rtl/linear_layer_start_fifo_ctrl_if.sv
// Start-FIFO handshake bundle: write side (ce/write/din/full_n),
// read side (ce/read/dout/empty_n); master = producer+consumer, slave = FIFO.
interface linear_layer_start_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;

  modport master (
    output if_write_ce, if_write, if_din,
    output if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n
  );

  modport slave (
    input  if_write_ce, if_write, if_din,
    input  if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/linear_layer_start_fifo_ctrl.sv
// Shift-register start FIFO. Ports: clk, reset_n (async low), bus (slave).
// START_FIFO_OREG_EN adds a registered output stage (capacity DEPTH+1).
module linear_layer_start_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input logic clk,
  input logic reset_n,
  linear_layer_start_fifo_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  full_n_q, empty_n_q;
  logic                  push, st_pop;
  logic [DATA_WIDTH-1:0] st_head;

  assign push = bus.if_write & bus.if_write_ce & full_n_q;
  assign st_head = mem_q[raddr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push & ~st_pop: cnt_d = cnt_q + 1'b1;
      st_pop & ~push: cnt_d = cnt_q - 1'b1;
      default:        cnt_d = cnt_q;
    endcase
  end

  // Newest entry sits at 0, so the head is at cnt-1.
  always_comb begin
    raddr_d = '0;
    if (cnt_d != '0)
      raddr_d = ADDR_WIDTH'(cnt_d - 1'b1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      raddr_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      raddr_q   <= raddr_d;
      full_n_q  <= (cnt_d != CW'(DEPTH));
      empty_n_q <= (cnt_d != '0);
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[0] <= bus.if_din;
      for (int i = DEPTH - 1; i > 0; i--)
        mem_q[i] <= mem_q[i-1];
    end
  end

  assign bus.if_full_n = full_n_q;

`ifdef START_FIFO_OREG_EN
  logic [DATA_WIDTH-1:0] oreg_q;
  logic                  ovld_q;
  logic                  opop;

  assign opop   = bus.if_read & bus.if_read_ce & ovld_q;
  // Refill the output register whenever it is free or being drained.
  assign st_pop = empty_n_q & (~ovld_q | opop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovld_q <= 1'b0;
    else if (st_pop)
      ovld_q <= 1'b1;
    else if (opop)
      ovld_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (st_pop)
      oreg_q <= st_head;
  end

  assign bus.if_dout    = oreg_q;
  assign bus.if_empty_n = ovld_q;
`else
  assign st_pop = bus.if_read & bus.if_read_ce & empty_n_q;

  assign bus.if_dout    = st_head;
  assign bus.if_empty_n = empty_n_q;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Bench for linear_layer_start_fifo_ctrl (default build).
// DEPTH=4 DUT with table + scoreboard, DEPTH=2 DUT for short sequence.
module tb_linear_layer_start_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] m4 [$];

  always #5 clk = ~clk;

  linear_layer_start_fifo_ctrl_if #(.DATA_WIDTH(8)) b4 ();
  linear_layer_start_fifo_ctrl_if #(.DATA_WIDTH(8)) b2 ();

  linear_layer_start_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)
  ) u4 (
    .clk(clk), .reset_n(rst_n), .bus(b4.slave)
  );

  linear_layer_start_fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)
  ) u2 (
    .clk(clk), .reset_n(rst_n), .bus(b2.slave)
  );

  typedef struct {
    bit         w;
    bit         wce;
    logic [7:0] d;
    bit         r;
    bit         rce;
    bit         exp_e;
    bit         exp_f;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock on the DEPTH=4 DUT with scoreboard update.
  task automatic cyc(input bit w, input bit wce, input logic [7:0] d,
                     input bit r, input bit rce);
    bit push, pop;
    b4.if_write = w;
    b4.if_write_ce = wce;
    b4.if_din = d;
    b4.if_read = r;
    b4.if_read_ce = rce;
    push = w && wce && (m4.size() < 4);
    pop  = r && rce && (m4.size() > 0);
    @(negedge clk);
    if (m4.size() > 0)
      chk("dout", b4.if_dout, m4[0]);
    @(posedge clk);
    #1;
    if (pop) void'(m4.pop_front());
    if (push) m4.push_back(d);
    chk("empty_n", b4.if_empty_n, m4.size() != 0);
    chk("full_n", b4.if_full_n, m4.size() != 4);
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1, 1, 8'hA0, 0, 0, 1, 1};
    tbl[1]  = '{1, 1, 8'hA1, 0, 0, 1, 1};
    tbl[2]  = '{1, 1, 8'hA2, 0, 0, 1, 1};
    tbl[3]  = '{1, 1, 8'hA3, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 8'hA4, 0, 0, 1, 0};
    tbl[5]  = '{1, 1, 8'hA5, 1, 1, 1, 1};
    tbl[6]  = '{1, 0, 8'hA6, 1, 0, 1, 1};
    tbl[7]  = '{0, 1, 8'hA7, 1, 1, 1, 1};
    tbl[8]  = '{1, 1, 8'hA8, 1, 1, 1, 1};
    tbl[9]  = '{0, 0, 8'h00, 1, 1, 1, 1};
    tbl[10] = '{0, 0, 8'h00, 1, 1, 0, 1};
    tbl[11] = '{0, 0, 8'h00, 1, 1, 0, 1};
    tbl[12] = '{1, 1, 8'hAC, 1, 1, 1, 1};
    tbl[13] = '{0, 0, 8'h00, 1, 1, 0, 1};

    {b4.if_write, b4.if_write_ce, b4.if_read, b4.if_read_ce} = '0;
    {b2.if_write, b2.if_write_ce, b2.if_read, b2.if_read_ce} = '0;
    b4.if_din = '0;
    b2.if_din = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty_n", b4.if_empty_n, 0);
    chk("rst_full_n", b4.if_full_n, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle with reads requested: nothing changes.
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 8'h00, 1, 1);

    // DEPTH=2: write 1 then 0, then drain.
    b2.if_write_ce = 1'b1;
    b2.if_write = 1'b1;
    b2.if_din = 8'h01;
    @(posedge clk);
    #1;
    b2.if_din = 8'h00;
    @(posedge clk);
    #1;
    b2.if_write = 1'b0;
    chk("d2_full_n", b2.if_full_n, 0);
    chk("d2_empty_n", b2.if_empty_n, 1);
    b2.if_read_ce = 1'b1;
    b2.if_read = 1'b1;
    @(negedge clk);
    chk("d2_rd0", b2.if_dout, 8'h01);
    @(posedge clk);
    #1;
    chk("d2_full_n1", b2.if_full_n, 1);
    @(negedge clk);
    chk("d2_rd1", b2.if_dout, 8'h00);
    @(posedge clk);
    #1;
    b2.if_read = 1'b0;
    chk("d2_empty_end", b2.if_empty_n, 0);

    // Table vectors on DEPTH=4.
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].w, tbl[i].wce, tbl[i].d, tbl[i].r, tbl[i].rce);
      chk($sformatf("tbl%0d_e", i), b4.if_empty_n, tbl[i].exp_e);
      chk($sformatf("tbl%0d_f", i), b4.if_full_n, tbl[i].exp_f);
    end

    // Steady push+pop at cnt=2.
    cyc(1, 1, 8'h10, 0, 0);
    cyc(1, 1, 8'h11, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 8'(8'h12 + i), 1, 1);
      chk("pp_cnt", m4.size(), 2);
    end

    // Fill to 3 then async reset mid-cycle.
    cyc(1, 1, 8'h20, 0, 0);
    b4.if_write = 1'b0;
    b4.if_read = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_empty_n", b4.if_empty_n, 0);
    chk("arst_full_n", b4.if_full_n, 1);
    m4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 1, 8'h5A, 0, 0);
    cyc(0, 0, 8'h00, 1, 1);
    chk("arst_drained", b4.if_empty_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/linear_layer_start_fifo_ctrl.md
LINEAR_LAYER_START_FIFO_CTRL -- requirements
Module: linear_layer_start_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 1, payload width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 1, width of the storage read index; 2^ADDR_WIDTH >= DEPTH.
REQ-003 The block SHALL have parameter DEPTH, default 2, storage entries; DEPTH >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port if_write_ce, input, 1 bit, write clock enable.
REQ-007 The block SHALL have port if_write, input, 1 bit, producer write request.
REQ-008 The block SHALL have port if_din, input, DATA_WIDTH bits, write payload.
REQ-009 The block SHALL have port if_full_n, output, 1 bit, high when a write is accepted.
REQ-010 The block SHALL have port if_read_ce, input, 1 bit, read clock enable.
REQ-011 The block SHALL have port if_read, input, 1 bit, consumer read request.
REQ-012 The block SHALL have port if_dout, output, DATA_WIDTH bits, head-of-queue payload.
REQ-013 The block SHALL have port if_empty_n, output, 1 bit, high when if_dout holds valid data.

Function
REQ-014 push SHALL be if_write & if_write_ce & if_full_n; pop SHALL be if_read & if_read_ce & if_empty_n.
REQ-015 Storage SHALL be a DEPTH-entry shift register: on push, entry[0] <= if_din and entry[i+1] <= entry[i]; no shift otherwise.
REQ-016 An occupancy counter cnt (0..DEPTH) SHALL increment on push-only, decrement on pop-only, and hold on push+pop or neither.
REQ-017 The read index SHALL equal cnt-1 when cnt>0 and 0 when cnt=0, registered, updated with cnt; on push+pop it SHALL be unchanged.
REQ-018 if_dout SHALL be the entry selected by the read index (combinational from storage); order SHALL be strict FIFO.
REQ-019 if_full_n SHALL be registered, low exactly when cnt=DEPTH; if_empty_n SHALL be registered, high exactly when cnt>0.
REQ-020 Write-to-read latency SHALL be 1 cycle: push at edge N makes if_empty_n high after edge N.
REQ-021 When full, a write SHALL be blocked even if a pop occurs in the same cycle; if_full_n rises the cycle after the pop.
REQ-022 When empty, a read SHALL be ignored; cnt SHALL never underflow or overflow.
REQ-023 With if_write_ce or if_read_ce low the corresponding request SHALL have no effect.

Reset
REQ-024 On reset_n low, asynchronously: cnt=0, read index=0, if_empty_n=0, if_full_n=1; storage contents SHALL NOT be reset.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries; first push after release behaves as from empty.
REQ-026 reset_n deassertion SHALL be treated as synchronous to clk by the integrator; no push/pop is accepted in the deassertion cycle's edge only if reset_n is low at that edge.

Configuration
REQ-027 Macro START_FIFO_OREG_EN, when defined, SHALL add a registered output stage: if_dout driven from a DATA_WIDTH register, if_empty_n meaning that register is valid.
REQ-028 With START_FIFO_OREG_EN, the output register SHALL load from storage head whenever storage cnt>0 and (register invalid or pop); capacity becomes DEPTH+1; write-to-if_empty_n latency becomes 2 cycles; output register valid flag resets to 0.
REQ-029 Without START_FIFO_OREG_EN, behaviour SHALL be exactly REQ-014..REQ-023 with no output register.

Verification
REQ-030 Reset then idle -> if_full_n=1, if_empty_n=0, no change for 10 cycles with if_read=1.
REQ-031 DEPTH=2, write 1 then 0 on consecutive cycles, no reads -> if_full_n=0 after second edge; reads return 1 then 0; if_empty_n=0 after second read.
REQ-032 DEPTH=4 full, if_write=1 and if_read=1 same cycle -> pop accepted, push rejected, cnt=3, if_full_n=1 next cycle.
REQ-033 cnt=2, simultaneous push+pop for 20 cycles with incrementing data -> cnt stays 2, read data is input delayed by 2 pops, no gaps.
REQ-034 cnt=3, reset_n pulsed low mid-cycle -> if_empty_n=0, if_full_n=1 immediately; next write/read returns new datum.
REQ-035 START_FIFO_OREG_EN defined, DEPTH=2 -> single write seen on if_empty_n after 2 edges; 3 writes accepted before if_full_n=0.
